// File: rtl/and_chain_ctrl_if.sv
// Handshake and operand/result bundle for and_chain_ctrl.
// The driver (lab top or bench) takes the master modport, the controller the slave.
interface and_chain_ctrl_if #(
  parameter int unsigned W = 1
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic         busy;
  logic         done;
  logic [W-1:0] e;
  logic [W-1:0] f;
  logic [W-1:0] g;

  modport master (
    output start, a, b, c, d,
    input  busy, done, e, f, g
  );

  modport slave (
    input  start, a, b, c, d,
    output busy, done, e, f, g
  );
endinterface

// File: rtl/and_chain_ctrl.sv
// Sequenced 4-operand AND chain (e=a&b, f=e&c, g=f&d) that evaluates one stage
// per clock through a single shared W-bit AND unit, with a start/busy/done handshake.
module and_chain_ctrl #(
  parameter int unsigned W          = 1,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  and_chain_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    S1,
    S2,
    S3,
    DONE
  } state_e;

  state_e       state_q;
  logic         busy_q;
  logic         done_q;
  logic [W-1:0] a_q, b_q, c_q, d_q;
  logic [W-1:0] e_q, f_q, g_q;

  logic [W-1:0] and_x;
  logic [W-1:0] and_y;
  logic [W-1:0] and_res;

  // Operand mux in front of the one shared AND unit.
  always_comb begin
    and_x = '0;
    and_y = '0;
    unique case (state_q)
      S1:      begin and_x = a_q; and_y = b_q; end
      S2:      begin and_x = e_q; and_y = c_q; end
      S3:      begin and_x = f_q; and_y = d_q; end
      default: begin and_x = '0;  and_y = '0;  end
    endcase
    and_res = and_x & and_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      g_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            c_q     <= bus.c;
            d_q     <= bus.d;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S1;
          end else begin
            state_q <= IDLE;
          end
        end
        S1: begin
          e_q <= and_res;
          if (EARLY_EXIT && (and_res == '0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= S2;
          end
        end
        S2: begin
          f_q <= and_res;
          if (EARLY_EXIT && (and_res == '0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= S3;
          end
        end
        S3: begin
          g_q     <= and_res;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.e    = e_q;
  assign bus.f    = f_q;
  assign bus.g    = g_q;

endmodule

// File: tb/tb_and_chain_ctrl.sv
// Directed bench for and_chain_ctrl: one instance without and one with early exit.
module tb_and_chain_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  and_chain_ctrl_if #(.W(4)) bus0 ();
  and_chain_ctrl_if #(.W(4)) bus1 ();

  and_chain_ctrl #(.W(4), .EARLY_EXIT(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  and_chain_ctrl #(.W(4), .EARLY_EXIT(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got0, got1;
    rst_n      = 1'b0;
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    bus0.a = 4'($urandom_range(0, 15)); bus0.b = 4'($urandom_range(0, 15));
    bus0.c = 4'($urandom_range(0, 15)); bus0.d = 4'($urandom_range(0, 15));
    bus1.a = 4'($urandom_range(0, 15)); bus1.b = 4'($urandom_range(0, 15));
    bus1.c = 4'($urandom_range(0, 15)); bus1.d = 4'($urandom_range(0, 15));
    for (int unsigned i = 0; i < 2; i++) begin
      step();
      got0 = {bus0.busy, bus0.done, bus0.e, bus0.f, bus0.g};
      got1 = {bus1.busy, bus1.done, bus1.e, bus1.f, bus1.g};
      checks++;
      if (got0 !== 14'h0) begin
        errors++;
        $display("FAIL reset_dut0 cyc%0d: got %h want 0000", i, got0);
      end
      checks++;
      if (got1 !== 14'h0) begin
        errors++;
        $display("FAIL reset_dut1 cyc%0d: got %h want 0000", i, got1);
      end
    end
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    rst_n      = 1'b1;
    step();
    checks++;
    if ({bus0.busy, bus1.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_busy: got %b want 00", {bus0.busy, bus1.busy});
    end
  endtask

  task automatic test_full_chain();
    // {busy, done, e, f, g} after edges t0..t5
    logic [13:0] exp_tab [6];
    logic [13:0] got;
    exp_tab[0] = {1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    exp_tab[1] = {1'b1, 1'b0, 4'hE, 4'h0, 4'h0};
    exp_tab[2] = {1'b1, 1'b0, 4'hE, 4'hC, 4'h0};
    exp_tab[3] = {1'b0, 1'b1, 4'hE, 4'hC, 4'h8};
    exp_tab[4] = {1'b0, 1'b0, 4'hE, 4'hC, 4'h8};
    exp_tab[5] = {1'b0, 1'b0, 4'hE, 4'hC, 4'h8};
    bus0.a = 4'hF; bus0.b = 4'hE; bus0.c = 4'hC; bus0.d = 4'h8;
    bus0.start = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin
        bus0.start = 1'b0;
        bus0.a = 4'h0; bus0.b = 4'h0; bus0.c = 4'h0; bus0.d = 4'h0;
      end
      got = {bus0.busy, bus0.done, bus0.e, bus0.f, bus0.g};
      checks++;
      if (got !== exp_tab[i]) begin
        errors++;
        $display("FAIL full_chain t%0d: got %h want %h", i, got, exp_tab[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int unsigned ndone = 0;
    bus0.a = 4'h7; bus0.b = 4'hF; bus0.c = 4'h3; bus0.d = 4'h1;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    step();
    bus0.a = 4'h0; bus0.b = 4'h0; bus0.c = 4'h0; bus0.d = 4'h0;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bus0.done === 1'b1) ndone++;
      step();
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignored_start_done_count: got %0d want 1", ndone);
    end
    checks++;
    if ({bus0.e, bus0.f, bus0.g} !== 12'h731) begin
      errors++;
      $display("FAIL ignored_start_result: got %h want 731", {bus0.e, bus0.f, bus0.g});
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_done;
    logic [3:0] exp_g;
    bus0.a = 4'hF; bus0.b = 4'hF; bus0.c = 4'hF; bus0.d = 4'hF;
    bus0.start = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      step();
      if (i % 4 == 0) begin
        // operands for the job accepted 4 edges from now
        bus0.b = ((i / 4) % 2 == 0) ? 4'h0 : 4'hF;
      end
      exp_done = (i % 4 == 3);
      checks++;
      if ({bus0.busy, bus0.done} !== {~exp_done, exp_done}) begin
        errors++;
        $display("FAIL b2b_handshake t%0d: got busy=%b done=%b want busy=%b done=%b",
                 i, bus0.busy, bus0.done, ~exp_done, exp_done);
      end
      if (exp_done) begin
        exp_g = ((i / 4) % 2 == 0) ? 4'hF : 4'h0;
        checks++;
        if (bus0.g !== exp_g) begin
          errors++;
          $display("FAIL b2b_g t%0d: got %h want %h", i, bus0.g, exp_g);
        end
      end
    end
    bus0.start = 1'b0;
    step();
  endtask

  task automatic test_early_exit();
    // exit in S1: b=0
    bus1.a = 4'hF; bus1.b = 4'h0; bus1.c = 4'hF; bus1.d = 4'hF;
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    step();
    checks++;
    if ({bus1.busy, bus1.done, bus1.e, bus1.f, bus1.g} !== {1'b0, 1'b1, 12'h000}) begin
      errors++;
      $display("FAIL early_s1: got %h want %h",
               {bus1.busy, bus1.done, bus1.e, bus1.f, bus1.g}, {1'b0, 1'b1, 12'h000});
    end
    step();
    checks++;
    if (bus1.done !== 1'b0) begin
      errors++;
      $display("FAIL early_s1_pulse: got done=%b want 0", bus1.done);
    end
    // exit in S2: c=0
    bus1.a = 4'hF; bus1.b = 4'h6; bus1.c = 4'h0; bus1.d = 4'hF;
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    step();
    checks++;
    if ({bus1.busy, bus1.done, bus1.e} !== {1'b1, 1'b0, 4'h6}) begin
      errors++;
      $display("FAIL early_s2_mid: got %h want %h", {bus1.busy, bus1.done, bus1.e}, {1'b1, 1'b0, 4'h6});
    end
    step();
    checks++;
    if ({bus1.busy, bus1.done, bus1.e, bus1.f, bus1.g} !== {1'b0, 1'b1, 12'h600}) begin
      errors++;
      $display("FAIL early_s2: got %h want %h",
               {bus1.busy, bus1.done, bus1.e, bus1.f, bus1.g}, {1'b0, 1'b1, 12'h600});
    end
    // zero only at the last stage: no early exit from S3
    bus1.a = 4'hF; bus1.b = 4'hF; bus1.c = 4'hF; bus1.d = 4'h0;
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    step();
    step();
    checks++;
    if ({bus1.busy, bus1.done} !== 2'b10) begin
      errors++;
      $display("FAIL early_s3_t2: got %b want 10", {bus1.busy, bus1.done});
    end
    step();
    checks++;
    if ({bus1.busy, bus1.done, bus1.e, bus1.f, bus1.g} !== {1'b0, 1'b1, 12'hFF0}) begin
      errors++;
      $display("FAIL early_s3_t3: got %h want %h",
               {bus1.busy, bus1.done, bus1.e, bus1.f, bus1.g}, {1'b0, 1'b1, 12'hFF0});
    end
    step();
  endtask

  task automatic test_mid_reset();
    int unsigned ndone = 0;
    bus0.a = 4'hF; bus0.b = 4'hF; bus0.c = 4'hF; bus0.d = 4'hF;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({bus0.busy, bus0.done, bus0.e, bus0.f, bus0.g} !== 14'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h want 0000",
               {bus0.busy, bus0.done, bus0.e, bus0.f, bus0.g});
    end
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      if (bus0.done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d pulses want 0", ndone);
    end
    bus0.a = 4'hF; bus0.b = 4'hE; bus0.c = 4'hC; bus0.d = 4'h8;
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({bus0.busy, bus0.done, bus0.e, bus0.f, bus0.g} !== {1'b0, 1'b1, 12'hEC8}) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h want %h",
               {bus0.busy, bus0.done, bus0.e, bus0.f, bus0.g}, {1'b0, 1'b1, 12'hEC8});
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c = '0; bus0.d = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.d = '0;
    test_reset();
    test_full_chain();
    test_ignored_start();
    test_back_to_back();
    test_early_exit();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
